// File: rtl/pipelined_control_unit_pkg.sv
// pipelined_control_unit_pkg: shared opcodes, functs, ALU/branch codes, control bundle and instruction class types
package ctrl_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int CODE_W     = 6;
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;
  localparam logic [5:0] FN_JR     = 6'h08;
  localparam logic [5:0] FN_MFHI   = 6'h10;
  localparam logic [5:0] FN_MFLO   = 6'h12;
  localparam logic [5:0] FN_MULT   = 6'h18;
  localparam logic [5:0] FN_MULTU  = 6'h19;
  localparam logic [CODE_W-1:0] BR_EQ  = 6'h03;
  localparam logic [CODE_W-1:0] BR_NE  = 6'h04;
  localparam logic [CODE_W-1:0] BR_LEZ = 6'h07;
  localparam logic [CODE_W-1:0] BR_GTZ = 6'h0F;
  localparam logic [CODE_W-1:0] BR_GEZ = 6'h11;
  localparam logic [CODE_W-1:0] BR_LTZ = 6'h13;
  localparam logic [CODE_W-1:0] ALU_HALT  = 6'h3F;
  localparam logic [CODE_W-1:0] ALU_RTYPE = 6'h02;
  typedef enum logic [2:0] {CL_R, CL_M, CL_J, CL_B, CL_I} instr_class_t;
  typedef struct packed {
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic                  is_signed;
    logic                  jump;
    logic                  branch;
    logic [1:0]            reg_dst;
    logic [REG_ADDR_W-1:0] dst_reg;
    logic [1:0]            alu_sel;
    logic [CODE_W-1:0]     alu_code;
    logic [CODE_W-1:0]     branch_code;
  } ctrl_bundle_t;
endpackage

// File: rtl/pipelined_control_unit_if.sv
// pipelined_control_unit_if: ID-side request (instr/flush/hold) and registered control bundle; master=fetch/testbench, slave=control unit
interface pipelined_control_unit_if;
  import ctrl_pkg::*;
  logic                  instr_valid;
  logic [31:0]           instr;
  logic                  flush;
  logic                  ex_hold;
  logic                  stall;
  logic                  ctl_valid;
  logic                  reg_write;
  logic                  mem_read;
  logic                  mem_write;
  logic                  mem_to_reg;
  logic                  is_signed;
  logic                  jump;
  logic                  branch;
  logic [1:0]            reg_dst;
  logic [REG_ADDR_W-1:0] dst_reg;
  logic [1:0]            alu_sel;
  logic [CODE_W-1:0]     alu_code;
  logic [CODE_W-1:0]     branch_code;
  logic                  mult_busy;
  modport master (
    output instr_valid, instr, flush, ex_hold,
    input  stall, ctl_valid, reg_write, mem_read, mem_write, mem_to_reg, is_signed, jump, branch,
           reg_dst, dst_reg, alu_sel, alu_code, branch_code, mult_busy
  );
  modport slave (
    input  instr_valid, instr, flush, ex_hold,
    output stall, ctl_valid, reg_write, mem_read, mem_write, mem_to_reg, is_signed, jump, branch,
           reg_dst, dst_reg, alu_sel, alu_code, branch_code, mult_busy
  );
endinterface

// File: rtl/pipelined_control_unit_decoder.sv
// ctrl_decoder: combinational instr -> control bundle, rt-usage, class (M = HI/LO-interlocked) and multiply flag; ports i_instr, o_bundle, o_uses_rt, o_cls, o_is_mult
module ctrl_decoder
  import ctrl_pkg::*;
(
  input  logic [31:0]  i_instr,
  output ctrl_bundle_t o_bundle,
  output logic         o_uses_rt,
  output instr_class_t o_cls,
  output logic         o_is_mult
);
  logic [5:0] w_op, w_fn;
  logic [4:0] w_rt, w_rd;
  assign w_op = i_instr[31:26];
  assign w_rt = i_instr[20:16];
  assign w_rd = i_instr[15:11];
  assign w_fn = i_instr[5:0];
  assign o_is_mult = w_op == OP_RTYPE && (w_fn == FN_MULT || w_fn == FN_MULTU);
  always_comb begin
    o_bundle = '0;
    o_uses_rt = 1'b0;
    o_cls = CL_I;
    case (w_op)
      OP_RTYPE: begin
        o_bundle.alu_code = ALU_RTYPE;
        o_bundle.reg_dst = 2'd1;
        o_bundle.dst_reg = w_rd;
        o_bundle.jump = w_fn == FN_JR;
        o_bundle.reg_write = !(o_is_mult || w_fn == FN_JR);
        o_uses_rt = 1'b1;
        o_cls = (o_is_mult || w_fn == FN_MFHI || w_fn == FN_MFLO) ? CL_M : CL_R;
      end
      OP_LW: begin
        o_bundle.alu_sel = 2'd1;
        o_bundle.is_signed = 1'b1;
        o_bundle.reg_write = 1'b1;
        o_bundle.mem_read = 1'b1;
        o_bundle.mem_to_reg = 1'b1;
        o_bundle.dst_reg = w_rt;
        o_bundle.alu_code = w_op;
      end
      OP_SW: begin
        o_bundle.alu_sel = 2'd1;
        o_bundle.is_signed = 1'b1;
        o_bundle.mem_write = 1'b1;
        o_bundle.dst_reg = w_rt;
        o_bundle.alu_code = w_op;
        o_uses_rt = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        o_bundle.branch = 1'b1;
        o_bundle.alu_code = ALU_HALT;
        o_bundle.branch_code = w_op == OP_BEQ ? BR_EQ : w_op == OP_BNE ? BR_NE : w_op == OP_BLEZ ? BR_LEZ : BR_GTZ;
        o_uses_rt = w_op == OP_BEQ || w_op == OP_BNE;
        o_cls = CL_B;
      end
      OP_REGIMM: begin
        // only BLTZ (rt=0) and BGEZ (rt=1) exist; everything else collapses to a NOP
        o_bundle.branch = w_rt < 5'd2;
        o_bundle.alu_code = w_rt < 5'd2 ? ALU_HALT : '0;
        o_bundle.branch_code = w_rt == 5'd0 ? BR_LTZ : w_rt == 5'd1 ? BR_GEZ : '0;
        o_cls = w_rt < 5'd2 ? CL_B : CL_R;
      end
      OP_J: begin
        o_bundle.jump = 1'b1;
        o_cls = CL_J;
      end
      OP_JAL: begin
        o_bundle.jump = 1'b1;
        o_bundle.reg_write = 1'b1;
        o_bundle.reg_dst = 2'd2;
        o_bundle.dst_reg = 5'd31;
        o_cls = CL_J;
      end
      default: begin
        o_bundle.alu_sel = 2'd1;
        o_bundle.reg_write = 1'b1;
        o_bundle.dst_reg = w_rt;
        o_bundle.alu_code = w_op;
      end
    endcase
  end
endmodule

// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: ID-stage decode with load-use/HI-LO stalls, flush, hold and multiplier tracking; ports clk, rst, bus (slave)
module pipelined_control_unit
  import ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 4
) (
  input logic clk,
  input logic rst,
  pipelined_control_unit_if.slave bus
);
  localparam int CW = $clog2(MULT_CYCLES + 1);
  ctrl_bundle_t w_dec, r_b;
  instr_class_t w_cls;
  logic w_uses_rt, w_is_mult, w_load_use, w_hilo_wait, w_load, r_valid;
  logic [CW-1:0] r_cnt;
  ctrl_decoder u_dec (
    .i_instr   (bus.instr),
    .o_bundle  (w_dec),
    .o_uses_rt (w_uses_rt),
    .o_cls     (w_cls),
    .o_is_mult (w_is_mult)
  );
  assign w_load_use = bus.instr_valid && r_valid && r_b.mem_read && r_b.dst_reg != '0 &&
                      (r_b.dst_reg == bus.instr[25:21] || (r_b.dst_reg == bus.instr[20:16] && w_uses_rt));
  assign w_hilo_wait = bus.instr_valid && r_cnt != '0 && w_cls == CL_M;
  assign w_load = !bus.flush && !bus.ex_hold && !w_load_use && !w_hilo_wait;
  assign bus.stall = (w_load_use || w_hilo_wait || bus.ex_hold) && !bus.flush;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_b <= '0;
      r_cnt <= '0;
    end else begin
      // the counter ignores flush/hold so an issued multiply always runs to completion
      r_cnt <= (w_load && bus.instr_valid && w_is_mult) ? CW'(MULT_CYCLES) : r_cnt != '0 ? r_cnt - CW'(1) : '0;
      if (!bus.ex_hold || bus.flush) begin
        r_valid <= w_load && bus.instr_valid;
        r_b <= (w_load && bus.instr_valid) ? w_dec : '0;
      end
    end
  end
  assign bus.ctl_valid   = r_valid;
  assign bus.reg_write   = r_b.reg_write;
  assign bus.mem_read    = r_b.mem_read;
  assign bus.mem_write   = r_b.mem_write;
  assign bus.mem_to_reg  = r_b.mem_to_reg;
  assign bus.is_signed   = r_b.is_signed;
  assign bus.jump        = r_b.jump;
  assign bus.branch      = r_b.branch;
  assign bus.reg_dst     = r_b.reg_dst;
  assign bus.dst_reg     = r_b.dst_reg;
  assign bus.alu_sel     = r_b.alu_sel;
  assign bus.alu_code    = r_b.alu_code;
  assign bus.branch_code = r_b.branch_code;
  assign bus.mult_busy   = r_cnt != '0;
endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb_pipelined_control_unit: directed self-checking bench for pipelined_control_unit
module tb_pipelined_control_unit;
  import ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst;
  int n_chk = 0;
  int n_fail = 0;
  ctrl_bundle_t hold_b;
  pipelined_control_unit_if bus ();
  pipelined_control_unit #(.MULT_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic ctrl_bundle_t obs();
    return '{reg_write: bus.reg_write, mem_read: bus.mem_read, mem_write: bus.mem_write,
             mem_to_reg: bus.mem_to_reg, is_signed: bus.is_signed, jump: bus.jump, branch: bus.branch,
             reg_dst: bus.reg_dst, dst_reg: bus.dst_reg, alu_sel: bus.alu_sel,
             alu_code: bus.alu_code, branch_code: bus.branch_code};
  endfunction
  function automatic ctrl_bundle_t bund(logic rw, mr, mw, m2r, sg, j, br, logic [1:0] rd,
                                        logic [4:0] dst, logic [1:0] as, logic [5:0] ac, bc);
    return '{reg_write: rw, mem_read: mr, mem_write: mw, mem_to_reg: m2r, is_signed: sg,
             jump: j, branch: br, reg_dst: rd, dst_reg: dst, alu_sel: as, alu_code: ac, branch_code: bc};
  endfunction
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] ins);
    bus.instr_valid = v;
    bus.instr = ins;
    #1;
  endtask
  initial begin
    rst = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    bus.flush = 1'b0;
    bus.ex_hold = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(bus.ctl_valid), 0);
    chk("rst_bundle", 32'(obs()), 0);
    chk("rst_busy", 32'(bus.mult_busy), 0);
    rst = 1'b0;
    drive(1, 32'h8C220004);
    chk("lw_nostall", 32'(bus.stall), 0);
    tick();
    chk("lw_valid", 32'(bus.ctl_valid), 1);
    chk("lw_bundle", 32'(obs()), 32'(bund(1,1,0,1,1,0,0,2'd0,5'd2,2'd1,6'h23,6'h00)));
    drive(1, 32'h00441821);
    chk("lu_rs_stall", 32'(bus.stall), 1);
    tick();
    chk("lu_bubble_valid", 32'(bus.ctl_valid), 0);
    chk("lu_bubble_bundle", 32'(obs()), 0);
    chk("lu_stall_released", 32'(bus.stall), 0);
    tick();
    chk("addu_valid", 32'(bus.ctl_valid), 1);
    chk("addu_bundle", 32'(obs()), 32'(bund(1,0,0,0,0,0,0,2'd1,5'd3,2'd0,6'h02,6'h00)));
    drive(1, 32'h8C220004);
    tick();
    drive(1, 32'h00821821);
    chk("lu_rt_stall", 32'(bus.stall), 1);
    tick();
    drive(1, 32'h8C220004);
    tick();
    drive(1, 32'h24220007);
    chk("itype_rt_nostall", 32'(bus.stall), 0);
    tick();
    chk("addiu_bundle", 32'(obs()), 32'(bund(1,0,0,0,0,0,0,2'd0,5'd2,2'd1,6'h09,6'h00)));
    drive(1, 32'h8C200004);
    tick();
    drive(1, 32'h00041821);
    chk("lw_r0_nostall", 32'(bus.stall), 0);
    tick();
    chk("after_r0_valid", 32'(bus.ctl_valid), 1);
    drive(1, 32'h00220018);
    tick();
    chk("mult_bundle", 32'(obs()), 32'(bund(0,0,0,0,0,0,0,2'd1,5'd0,2'd0,6'h02,6'h00)));
    drive(1, 32'h00002812);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("mflo_busy%0d", i), 32'(bus.mult_busy), 1);
      chk($sformatf("mflo_stall%0d", i), 32'(bus.stall), 1);
      tick();
      chk($sformatf("mflo_bubble%0d", i), 32'(bus.ctl_valid), 0);
    end
    chk("mult_done_busy", 32'(bus.mult_busy), 0);
    chk("mult_done_stall", 32'(bus.stall), 0);
    tick();
    chk("mflo_valid", 32'(bus.ctl_valid), 1);
    chk("mflo_bundle", 32'(obs()), 32'(bund(1,0,0,0,0,0,0,2'd1,5'd5,2'd0,6'h02,6'h00)));
    drive(1, 32'h14220003);
    tick();
    chk("bne_bundle", 32'(obs()), 32'(bund(0,0,0,0,0,0,1,2'd0,5'd0,2'd0,6'h3F,6'h04)));
    drive(1, 32'h04210002);
    tick();
    chk("bgez_bundle", 32'(obs()), 32'(bund(0,0,0,0,0,0,1,2'd0,5'd0,2'd0,6'h3F,6'h11)));
    drive(1, 32'h04200002);
    tick();
    chk("bltz_bundle", 32'(obs()), 32'(bund(0,0,0,0,0,0,1,2'd0,5'd0,2'd0,6'h3F,6'h13)));
    drive(1, 32'h04250002);
    tick();
    chk("regimm_nop_valid", 32'(bus.ctl_valid), 1);
    chk("regimm_nop_bundle", 32'(obs()), 0);
    drive(1, 32'h8C220004);
    tick();
    bus.flush = 1'b1;
    drive(1, 32'h00430018);
    chk("flush_stall", 32'(bus.stall), 0);
    tick();
    chk("flush_valid", 32'(bus.ctl_valid), 0);
    chk("flush_bundle", 32'(obs()), 0);
    chk("flush_no_mult", 32'(bus.mult_busy), 0);
    bus.flush = 1'b0;
    drive(1, 32'h24250007);
    tick();
    hold_b = bund(1,0,0,0,0,0,0,2'd0,5'd5,2'd1,6'h09,6'h00);
    chk("pre_hold_bundle", 32'(obs()), 32'(hold_b));
    bus.ex_hold = 1'b1;
    drive(1, 32'h00220018);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("hold_stall%0d", i), 32'(bus.stall), 1);
      tick();
      chk($sformatf("hold_bundle%0d", i), 32'(obs()), 32'(hold_b));
      chk($sformatf("hold_valid%0d", i), 32'(bus.ctl_valid), 1);
      chk($sformatf("hold_no_mult%0d", i), 32'(bus.mult_busy), 0);
    end
    bus.ex_hold = 1'b0;
    drive(0, 32'h00220018);
    tick();
    chk("invalid_valid", 32'(bus.ctl_valid), 0);
    chk("invalid_bundle", 32'(obs()), 0);
    chk("invalid_no_mult", 32'(bus.mult_busy), 0);
    drive(1, 32'h0C000010);
    tick();
    chk("jal_bundle", 32'(obs()), 32'(bund(1,0,0,0,0,1,0,2'd2,5'd31,2'd0,6'h00,6'h00)));
    drive(1, 32'hAC220000);
    tick();
    chk("sw_bundle", 32'(obs()), 32'(bund(0,0,1,0,1,0,0,2'd0,5'd2,2'd1,6'h2B,6'h00)));
    drive(1, 32'h00220018);
    tick();
    drive(0, 32'h0);
    tick();
    chk("mid_mult_busy", 32'(bus.mult_busy), 1);
    rst = 1'b1;
    tick();
    chk("rst_mult_busy", 32'(bus.mult_busy), 0);
    chk("rst_mult_valid", 32'(bus.ctl_valid), 0);
    rst = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- Next-generation MIPS decode/control stage. Decodes the IF/ID instruction word and registers a complete control bundle into the ID/EX boundary.
- Adds behaviour the previous purely combinational controller lacked:
  - load-use hazard stall
  - multi-cycle multiplier busy tracking with HI/LO interlock
  - branch flush
  - downstream hold
  - JAL link-register destination
- Sits between the fetch/IF-ID register and the execute stage. Drives the branch resolution unit and the ALU.

Parameters:
- MULT_CYCLES, 4, multiplier latency in cycles (>=1); HI/LO valid MULT_CYCLES cycles after issue
- REG_ADDR_W, 5, register-index width
- CODE_W, 6, width of alu_code and branch_code

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- instr_valid  in  1  instr holds a real instruction
- instr  in  32  instruction word (op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0])
- flush  in  1  branch/jump taken; squash the instruction in ID
- ex_hold  in  1  execute stage cannot accept; freeze bundle
- stall  out  1  to IF: hold PC and IF/ID (combinational)
- ctl_valid  out  1  bundle holds a real instruction
- reg_write, mem_read, mem_write, mem_to_reg, is_signed, jump, branch  out  1 each  control flags
- reg_dst  out  2  0=rt, 1=rd, 2=r31
- dst_reg  out  REG_ADDR_W  resolved destination index
- alu_sel  out  2  0=register B, 1=immediate
- alu_code  out  CODE_W  ALU operation
- branch_code  out  CODE_W  comparison for branch unit
- mult_busy  out  1  multiplier in flight

Behaviour:
- All bundle outputs are registered with one-cycle latency from ID. stall is combinational.

Reset:
- rst is sampled at the clock edge.
- All bundle outputs, ctl_valid, and mult_busy are 0; the counter is 0.

Decode by opcode:
- 0x00 R-type: alu_code=0x02, reg_dst=1, reg_write=1.
  - Exceptions: MULT(0x18)/MULTU(0x19) set reg_write=0.
  - JR(funct 0x08) sets jump=1, reg_write=0.
- 0x23 LW: alu_sel=1, is_signed=1, reg_write=1, mem_read=1, mem_to_reg=1, reg_dst=0.
- 0x2B SW: alu_sel=1, is_signed=1, mem_write=1, reg_write=0.
- Branches set branch=1 and alu_code=0x3F (ALU idle):
  - 0x04 -> branch_code=0x03
  - 0x05 -> 0x04
  - 0x06 -> 0x07
  - 0x07 -> 0x0F
  - 0x01: rt=0 -> 0x13; rt=1 -> 0x11; any other rt -> decoded as NOP.
- 0x02 J: jump=1.
- 0x03 JAL: jump=1, reg_write=1, reg_dst=2, dst_reg=31.
- Any other opcode is I-type: alu_sel=1, reg_write=1, reg_dst=0, alu_code=opcode.
- branch_code is 0 for every non-branch. No field is ever left undefined.

Hazards (evaluated only when instr_valid=1):
- load_use: ctl_valid & mem_read & dst_reg!=0 & (dst_reg==rs | (dst_reg==rt & instr uses rt)).
  - rt is used by R-type, SW, and opcodes 0x04/0x05.
- hilo_wait: mult_busy & instr is MFHI(0x10), MFLO(0x12), MULT, or MULTU.
- stall = (load_use | hilo_wait | ex_hold) & ~flush.

Register update priority (highest first):
1. rst: clear.
2. flush: bundle becomes a bubble (ctl_valid=0, all flags 0).
3. ex_hold: bundle holds its current value.
4. load_use or hilo_wait: insert a bubble.
5. Otherwise: load the decoded bundle; ctl_valid=instr_valid.
- An invalid instruction (instr_valid=0) always produces an all-zero bundle.

Multiplier counter:
- Loads MULT_CYCLES when a MULT/MULTU bundle is loaded (priority 5 only).
- Otherwise decrements each cycle while nonzero. It is never affected by flush or ex_hold; an issued multiply always completes.
- mult_busy = counter != 0.
- A flushed or stalled MULT never loads the counter.
- MULT_CYCLES=1 gives a single busy cycle.

Decomposition:
- ctrl_pkg holds:
  - opcode and funct localparams
  - branch codes 0x03/0x04/0x07/0x0F/0x11/0x13
  - ALU_HALT=0x3F, ALU_RTYPE=0x02
  - a packed ctrl_bundle_t struct and an instr_class_t enum {R,M,J,B,I}. The enum is 3 bits wide, since 5 values do not fit in 2.
- Sub-module ctrl_decoder: purely combinational, instr -> ctrl_bundle_t plus uses_rt. The top level owns the hazard logic, counter, and pipeline register.

Test Plan:
1. Reset, then instr 0x8C220004 (LW r2,4(r1)) -> next cycle ctl_valid=1, mem_read=1, mem_to_reg=1, dst_reg=2, alu_sel=1.
2. LW r2 followed by ADDU r3,r2,r4 -> stall=1 for exactly 1 cycle, bubble (ctl_valid=0) inserted, then ADDU issues with reg_dst=1, dst_reg=3. With dst r0, no stall.
3. MULT with MULT_CYCLES=4, then MFLO next cycle -> mult_busy=1 for 4 cycles, stall=1 for 4 cycles, MFLO issues on the 5th cycle after MULT.
4. BNE (op 0x05) -> branch=1, alu_code=0x3F, branch_code=0x04. REGIMM with rt=1 -> branch_code=0x11; rt=0 -> 0x13; rt=5 -> NOP bundle.
5. flush asserted together with load_use and a MULT -> bubble, stall=0, counter unchanged. ex_hold=1 for 3 cycles -> bundle frozen and stall=1 throughout.
6. JAL (op 0x03) -> jump=1, reg_write=1, reg_dst=2, dst_reg=31. SW 0xAC220000 -> mem_write=1, reg_write=0. rst mid-multiply -> mult_busy=0 next cycle.
